// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF measurement sequencer.
package puf_pkg;

    // Sequencer states: one bit is measured per CLEAR..SAMPLE loop.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } puf_state_t;

    localparam int CLEAR_CYCLES          = 2;
    localparam int DEF_WIN_CYCLES        = 64;
    localparam int DEF_SETTLE_CYCLES     = 4;
    localparam int DEF_NBITS             = 8;

    localparam int CHAL_W                = 5;   // challenge select width
    localparam int CNT_W                 = 8;   // ring-oscillator count width
    localparam int RESP_W                = 8;   // response word width
    localparam int TIE_W                 = 4;   // saturating tie counter width
    localparam int K_W                   = 3;   // bit index width

    // Largest of three durations; sizes the shared window timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/puf_measure_ctrl_if.sv
// Request/response side of the measurement sequencer.
interface puf_measure_ctrl_if;
    import puf_pkg::*;

    logic              start;
    logic [CHAL_W-1:0] chal_base;
    logic              busy;
    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] resp;
    logic [TIE_W-1:0]  tie_cnt;

    // Requester / response consumer
    modport master (
        output start, chal_base, resp_ready,
        input  busy, resp_valid, resp, tie_cnt
    );

    // Sequencer
    modport slave (
        input  start, chal_base, resp_ready,
        output busy, resp_valid, resp, tie_cnt
    );
endinterface

// File: rtl/puf_window_timer.sv
// Loadable down-counter shared by the CLEAR, RUN and SETTLE phases.
// Loading N makes done assert during the Nth cycle after the load edge,
// so a state that loads N on entry and leaves on done lasts N cycles.
module puf_window_timer #(
    parameter int CNT_BITS = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [CNT_BITS-1:0] load_val,
    output logic                done
);

    logic [CNT_BITS-1:0] cnt_reg;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_BITS'(1);
        end
    end

    assign done = (cnt_reg == CNT_BITS'(1));

endmodule

// File: rtl/puf_measure_ctrl.sv
// Measurement sequencer for a dual ring-oscillator PUF. For each of NBITS
// consecutive challenges it clears the counters, runs the oscillators for
// a timed window, lets the counts settle, samples them and records one
// response bit (cnt_a > cnt_b). The finished word is offered on a
// valid/ready handshake. All outputs come straight from flops.
module puf_measure_ctrl
    import puf_pkg::*;
#(
    parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int NBITS         = DEF_NBITS
) (
    input  logic               clk,
    input  logic               rst_n,
    puf_measure_ctrl_if.slave  ctl,
    output logic [CHAL_W-1:0]  sel,
    output logic               osc_en,
    output logic               cnt_clr,
    input  logic [CNT_W-1:0]   cnt_a,
    input  logic [CNT_W-1:0]   cnt_b
);

    localparam int TMR_MAX = max3(WIN_CYCLES, SETTLE_CYCLES, CLEAR_CYCLES);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] CLR_LOAD = TMR_W'(CLEAR_CYCLES);
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WIN_CYCLES);
    localparam logic [TMR_W-1:0] STL_LOAD = TMR_W'(SETTLE_CYCLES);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(NBITS - 1);

    puf_state_t          state_reg, state_next;
    logic [CHAL_W-1:0]   chal_reg;
    logic [K_W-1:0]      k_reg;
    logic [RESP_W-1:0]   resp_reg;
    logic [TIE_W-1:0]    tie_reg;
    logic [CNT_W-1:0]    cnt_a_reg, cnt_b_reg;
    logic [CHAL_W-1:0]   sel_reg, sel_next;
    logic                osc_en_reg, cnt_clr_reg, busy_reg, valid_reg;

    logic                timer_load;
    logic [TMR_W-1:0]    timer_val;
    logic                timer_done;

    logic [RESP_W-1:0]   bit_sel;
    logic                a_gt_b, a_eq_b;
    logic                start_acc;

    puf_window_timer #(
        .CNT_BITS (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    assign start_acc = (state_reg == ST_IDLE) && ctl.start;
    assign a_gt_b    = (cnt_a_reg > cnt_b_reg);
    assign a_eq_b    = (cnt_a_reg == cnt_b_reg);

    // One-hot lane for the current bit; lanes at or above NBITS never set.
    genvar gi;
    generate
        for (gi = 0; gi < RESP_W; gi++) begin : g_bit_sel
            if (gi < NBITS) begin : g_live
                assign bit_sel[gi] = (k_reg == K_W'(gi));
            end else begin : g_dead
                assign bit_sel[gi] = 1'b0;
            end
        end
    endgenerate

    // Next-state logic and timer reload on entry to each timed phase.
    always_comb begin
        state_next = state_reg;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (ctl.start) begin
                    state_next = ST_CLEAR;
                    timer_load = 1'b1;
                    timer_val  = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                if (timer_done) begin
                    state_next = ST_RUN;
                    timer_load = 1'b1;
                    timer_val  = WIN_LOAD;
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    state_next = ST_SETTLE;
                    timer_load = 1'b1;
                    timer_val  = STL_LOAD;
                end
            end
            ST_SETTLE: begin
                if (timer_done) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (k_reg == LAST_K) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CLEAR;
                    timer_load = 1'b1;
                    timer_val  = CLR_LOAD;
                end
            end
            ST_DONE: begin
                if (ctl.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Challenge for the bit about to start: base on a new request, else base+k+1.
    always_comb begin
        sel_next = sel_reg;
        if (start_acc) begin
            sel_next = ctl.chal_base;
        end else if (state_reg == ST_SAMPLE && state_next == ST_CLEAR) begin
            sel_next = chal_reg + CHAL_W'(k_reg) + CHAL_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Request latch, count capture and response/tie accumulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chal_reg  <= '0;
            k_reg     <= '0;
            resp_reg  <= '0;
            tie_reg   <= '0;
            cnt_a_reg <= '0;
            cnt_b_reg <= '0;
        end else begin
            if (start_acc) begin
                chal_reg <= ctl.chal_base;
                k_reg    <= '0;
                resp_reg <= '0;
                tie_reg  <= '0;
            end
            // Counts are frozen by the end of SETTLE; capture on the way into SAMPLE.
            if (state_reg == ST_SETTLE && state_next == ST_SAMPLE) begin
                cnt_a_reg <= cnt_a;
                cnt_b_reg <= cnt_b;
            end
            if (state_reg == ST_SAMPLE) begin
                resp_reg <= resp_reg | (bit_sel & {RESP_W{a_gt_b}});
                if (a_eq_b && (tie_reg != {TIE_W{1'b1}})) begin
                    tie_reg <= tie_reg + TIE_W'(1);
                end
                if (state_next == ST_CLEAR) begin
                    k_reg <= k_reg + K_W'(1);
                end
            end
        end
    end

    // Registered outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg     <= '0;
            osc_en_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            sel_reg     <= sel_next;
            osc_en_reg  <= (state_next == ST_RUN);
            cnt_clr_reg <= (state_next == ST_CLEAR);
            busy_reg    <= (state_next != ST_IDLE);
            valid_reg   <= (state_next == ST_DONE);
        end
    end

    assign sel            = sel_reg;
    assign osc_en         = osc_en_reg;
    assign cnt_clr        = cnt_clr_reg;
    assign ctl.busy       = busy_reg;
    assign ctl.resp_valid = valid_reg;
    assign ctl.resp       = resp_reg;
    assign ctl.tie_cnt    = tie_reg;

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Directed bench for puf_measure_ctrl: default-parameter instance plus a
// minimal NBITS=1 / WIN=1 / SETTLE=2 corner instance on the same clock.
module tb_puf_measure_ctrl;
    import puf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    puf_measure_ctrl_if ctl ();
    puf_measure_ctrl_if ctl_c ();

    logic [CHAL_W-1:0] sel, sel_c;
    logic              osc_en, cnt_clr, osc_en_c, cnt_clr_c;
    logic [CNT_W-1:0]  cnt_a, cnt_b, cnt_a_c, cnt_b_c;

    int                mode = 0;
    logic [CHAL_W-1:0] base_m = '0;
    logic [CHAL_W-1:0] kk;

    int n_checks = 0;
    int n_pass   = 0;

    // Oscillator stage model: counts as a function of the current challenge.
    always_comb begin
        kk    = sel - base_m;
        cnt_a = 8'h50;
        cnt_b = 8'h40;
        if (mode == 1) begin
            if (kk[0]) begin
                cnt_a = 8'h33;
                cnt_b = 8'h33;
            end else begin
                cnt_a = 8'h10;
                cnt_b = 8'h20;
            end
        end
    end

    assign cnt_a_c = 8'h01;
    assign cnt_b_c = 8'h00;

    puf_measure_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (ctl),
        .sel     (sel),
        .osc_en  (osc_en),
        .cnt_clr (cnt_clr),
        .cnt_a   (cnt_a),
        .cnt_b   (cnt_b)
    );

    puf_measure_ctrl #(
        .WIN_CYCLES    (1),
        .SETTLE_CYCLES (2),
        .NBITS         (1)
    ) dut_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (ctl_c),
        .sel     (sel_c),
        .osc_en  (osc_en_c),
        .cnt_clr (cnt_clr_c),
        .cnt_a   (cnt_a_c),
        .cnt_b   (cnt_b_c)
    );

    // Output monitors (DUT outputs change only on posedge).
    logic [CHAL_W-1:0] sel_q[$];
    bit clr_prev = 1'b0;
    int overlap_cnt = 0;
    int osc_c_cnt   = 0;
    always @(negedge clk) begin
        clr_prev <= cnt_clr;
        if (cnt_clr && !clr_prev) sel_q.push_back(sel);
        if ((osc_en && cnt_clr) || (osc_en_c && cnt_clr_c)) overlap_cnt <= overlap_cnt + 1;
        if (osc_en_c) osc_c_cnt <= osc_c_cnt + 1;
    end

    // Handshake monitor on the active edge (ready only changes on negedge).
    int valid_cnt = 0;
    int xfer_cnt  = 0;
    always @(posedge clk) begin
        if (ctl.resp_valid) valid_cnt <= valid_cnt + 1;
        if (ctl.resp_valid && ctl.resp_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue a start and count cycles from the accepting edge to resp_valid.
    task automatic run_meas(input logic [CHAL_W-1:0] base, output int cyc);
        @(negedge clk);
        ctl.start     = 1'b1;
        ctl.chal_base = base;
        @(negedge clk);
        ctl.start     = 1'b0;
        cyc = 0;
        while (!ctl.resp_valid && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic xfer(input string tag);
        @(negedge clk);
        ctl.resp_ready = 1'b1;
        @(negedge clk);
        ctl.resp_ready = 1'b0;
        check({tag, "_valid_low"}, 32'(ctl.resp_valid), 32'd0);
        check({tag, "_busy_low"}, 32'(ctl.busy), 32'd0);
    endtask

    task automatic check_sels(input string tag, input int q0, input logic [CHAL_W-1:0] base);
        logic [CHAL_W-1:0] exp_sel;
        check({tag, "_sel_count"}, 32'(sel_q.size() - q0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            exp_sel = base + CHAL_W'(i);
            if (q0 + i < sel_q.size()) check({tag, "_sel"}, 32'(sel_q[q0 + i]), 32'(exp_sel));
        end
    endtask

    initial begin
        int cyc, q0, v0, x0, bad, oc0;
        logic [RESP_W-1:0] r0;

        rst_n = 1'b0;
        ctl.start = 1'b0;   ctl.chal_base = '0;   ctl.resp_ready = 1'b0;
        ctl_c.start = 1'b0; ctl_c.chal_base = '0; ctl_c.resp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(ctl.busy), 32'd0);
        check("rst_valid", 32'(ctl.resp_valid), 32'd0);
        check("rst_resp", 32'(ctl.resp), 32'd0);
        check("rst_tie", 32'(ctl.tie_cnt), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_osc_en", 32'(osc_en), 32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        rst_n = 1'b1;
        $display("reset released");

        // Basic measurement: a > b on every challenge
        mode = 0; base_m = 5'd3; q0 = sel_q.size();
        run_meas(5'd3, cyc);
        $display("basic: latency=%0d resp=0x%0h tie=%0d", cyc, ctl.resp, ctl.tie_cnt);
        check("basic_latency", 32'(cyc), 32'd568);
        check("basic_resp", 32'(ctl.resp), 32'hFF);
        check("basic_tie", 32'(ctl.tie_cnt), 32'd0);
        check("basic_busy", 32'(ctl.busy), 32'd1);
        check_sels("basic", q0, 5'd3);
        xfer("basic");

        // Wrap and ties, ready already high when DONE is entered
        mode = 1; base_m = 5'd30; q0 = sel_q.size(); v0 = valid_cnt;
        ctl.resp_ready = 1'b1;
        run_meas(5'd30, cyc);
        $display("wrap: latency=%0d resp=0x%0h tie=%0d", cyc, ctl.resp, ctl.tie_cnt);
        check("wrap_latency", 32'(cyc), 32'd568);
        check("wrap_resp", 32'(ctl.resp), 32'h00);
        check("wrap_tie", 32'(ctl.tie_cnt), 32'd4);
        @(negedge clk);
        check("wrap_valid_low", 32'(ctl.resp_valid), 32'd0);
        check("wrap_busy_low", 32'(ctl.busy), 32'd0);
        check("wrap_valid_cycles", 32'(valid_cnt - v0), 32'd1);
        ctl.resp_ready = 1'b0;
        check_sels("wrap", q0, 5'd30);

        // Backpressure: hold ready low, poke start, then one transfer
        mode = 0; base_m = 5'd10;
        run_meas(5'd10, cyc);
        check("bp_latency", 32'(cyc), 32'd568);
        r0 = ctl.resp; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ctl.start = (i % 10 == 3);
            ctl.chal_base = 5'd0;
            if (ctl.resp !== r0 || ctl.resp_valid !== 1'b1 || ctl.busy !== 1'b1) bad++;
        end
        ctl.start = 1'b0;
        $display("backpressure: resp=0x%0h held_violations=%0d", ctl.resp, bad);
        check("bp_resp", 32'(ctl.resp), 32'hFF);
        check("bp_stable", 32'(bad), 32'd0);
        x0 = xfer_cnt;
        @(negedge clk);
        ctl.resp_ready = 1'b1;
        ctl.start = 1'b1;
        @(negedge clk);
        ctl.resp_ready = 1'b0;
        ctl.start = 1'b0;
        check("bp_valid_low", 32'(ctl.resp_valid), 32'd0);
        check("bp_busy_low", 32'(ctl.busy), 32'd0);
        repeat (5) @(negedge clk);
        check("bp_start_ignored", 32'(ctl.busy), 32'd0);
        check("bp_xfers", 32'(xfer_cnt - x0), 32'd1);

        // Reset during RUN of bit 3
        mode = 0; base_m = 5'd0;
        @(negedge clk);
        ctl.start = 1'b1; ctl.chal_base = 5'd0;
        @(negedge clk);
        ctl.start = 1'b0;
        cyc = 0;
        while (!(sel == 5'd3 && osc_en) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (5) @(negedge clk);
        check("prerst_osc_en", 32'(osc_en), 32'd1);
        check("prerst_sel", 32'(sel), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        $display("mid-run reset: osc_en=%0d busy=%0d resp=0x%0h", osc_en, ctl.busy, ctl.resp);
        check("mrst_osc_en", 32'(osc_en), 32'd0);
        check("mrst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("mrst_busy", 32'(ctl.busy), 32'd0);
        check("mrst_valid", 32'(ctl.resp_valid), 32'd0);
        check("mrst_resp", 32'(ctl.resp), 32'd0);
        check("mrst_tie", 32'(ctl.tie_cnt), 32'd0);
        check("mrst_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_cnt;
        repeat (700) @(negedge clk);
        check("mrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("mrst_idle", 32'(ctl.busy), 32'd0);
        base_m = 5'd5;
        run_meas(5'd5, cyc);
        $display("after reset: latency=%0d resp=0x%0h", cyc, ctl.resp);
        check("mrst_latency", 32'(cyc), 32'd568);
        check("mrst_resp2", 32'(ctl.resp), 32'hFF);
        xfer("mrst");

        // Parameter corner instance
        oc0 = osc_c_cnt;
        @(negedge clk);
        ctl_c.start = 1'b1; ctl_c.chal_base = 5'd7;
        @(negedge clk);
        ctl_c.start = 1'b0;
        cyc = 0;
        while (!ctl_c.resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        $display("corner: latency=%0d resp=0x%0h osc_cycles=%0d", cyc, ctl_c.resp, osc_c_cnt - oc0);
        check("corner_latency", 32'(cyc), 32'd6);
        check("corner_resp", 32'(ctl_c.resp), 32'h01);
        check("corner_tie", 32'(ctl_c.tie_cnt), 32'd0);
        check("corner_osc_cycles", 32'(osc_c_cnt - oc0), 32'd1);
        check("corner_sel", 32'(sel_c), 32'd7);
        @(negedge clk);
        ctl_c.resp_ready = 1'b1;
        @(negedge clk);
        ctl_c.resp_ready = 1'b0;
        check("corner_valid_low", 32'(ctl_c.resp_valid), 32'd0);

        check("osc_clr_overlap", 32'(overlap_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/puf_measure_ctrl.md
# puf_measure_ctrl

Synchronous measurement sequencer that sits directly downstream of the dual ring-oscillator counter stage. It drives the challenge select, oscillator enable and counter clear into that stage. After each timed window it samples the two frozen 8-bit counts and converts each comparison into one response bit. It assembles NBITS bits over consecutive challenges into a response word and delivers it on a valid/ready handshake.

## Interface
Parameters:
- WIN_CYCLES, 64: clk cycles the oscillators are enabled per bit (≥1).
- SETTLE_CYCLES, 4: clk cycles after disabling before counts are sampled (≥2).
- NBITS, 8: response bits per measurement (1..8).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- chal_base  in  5  first challenge; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- resp_valid  out  1  response word available.
- resp_ready  in  1  consumer accepts response.
- resp  out  8  response word; bits ≥ NBITS read 0.
- tie_cnt  out  4  count of equal-count comparisons in the last measurement, saturating at 15.
- sel  out  5  challenge select to the oscillator stage.
- osc_en  out  1  oscillator enable.
- cnt_clr  out  1  active-high clear to both counters.
- cnt_a, cnt_b  in  8  counts from the two counter chains. They are asynchronous but static while osc_en is low and past settle.

## Operation
- FSM states: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE.
- IDLE → CLEAR when start=1.
  - On that edge: latch chal_base, set bit index k=0, clear the resp shift register and tie_cnt.
- CLEAR (2 cycles): cnt_clr=1, osc_en=0, sel=chal_base+k (mod 32, 5-bit wrap). Then → RUN.
- RUN (WIN_CYCLES cycles): osc_en=1, cnt_clr=0, sel held. Then → SETTLE.
- SETTLE (SETTLE_CYCLES cycles): osc_en=0, sel held. Then → SAMPLE.
- SAMPLE (1 cycle): register cnt_a and cnt_b, then compare unsigned.
  - resp[k] = (cnt_a > cnt_b).
  - If the counts are equal, the bit is 0 and tie_cnt is incremented (saturating).
  - If k = NBITS-1 → DONE; otherwise k++ → CLEAR.
- DONE: resp_valid=1. resp and tie_cnt stay stable until resp_ready=1, then → IDLE.
- start outside IDLE is ignored, including on the cycle the DONE handshake completes.
- The counters wrap at 8 bits, so a count that wraps is not detected. The integrator sizes WIN_CYCLES so counts stay below 256.

## Timing
- Reset values: busy=0, resp_valid=0, resp=0, tie_cnt=0, sel=0, osc_en=0, cnt_clr=0, state=IDLE.
- Reset asserted mid-measurement forces all outputs to their reset values immediately (osc_en drops asynchronously). No partial response is ever presented.
- Per-bit cost: WIN_CYCLES+SETTLE_CYCLES+3 cycles. With defaults this is 71.
- Latency: resp_valid rises NBITS·(WIN_CYCLES+SETTLE_CYCLES+3) cycles after the start-accepting edge. With defaults this is 568 cycles.
- All outputs are registered, and osc_en and cnt_clr are never high in the same cycle.
- Handshake transfer occurs on the edge where resp_valid=1 and resp_ready=1. resp_valid is low on the following cycle.
- If resp_ready is already high when DONE is entered, resp_valid is high for exactly one cycle.
- busy falls on the same edge as resp_valid.

## Structure
- Package puf_pkg holds:
  - the FSM state enum;
  - CLEAR_CYCLES=2;
  - the default WIN_CYCLES, SETTLE_CYCLES and NBITS values;
  - the 5-bit challenge and 8-bit count widths.
- One sub-module, puf_window_timer. It is a loadable down-counter with load value and a done pulse, sized to max(WIN_CYCLES, SETTLE_CYCLES). It is reused for the CLEAR, RUN and SETTLE durations.

## Test plan
- Basic measurement: model cnt_a=0x50 and cnt_b=0x40 for every challenge; start with chal_base=3. Expect resp=0xFF, tie_cnt=0, resp_valid at cycle 568, and sel stepping 3,4,…,10.
- Wrap and ties: chal_base=30, cnt_a=cnt_b on odd k, cnt_a<cnt_b on even k. Expect sel sequence 30,31,0,…,5, resp=0x00, tie_cnt=4.
- Backpressure: hold resp_ready=0 for 50 cycles after valid. Expect resp stable, busy=1 and start pulses ignored; after ready, exactly one transfer and return to IDLE.
- Reset mid-run: assert rst_n=0 during RUN of bit 3. Expect osc_en=0 and all outputs at reset values immediately, and no resp_valid afterwards. A new start yields a full, correct measurement.
- Parameter corner: NBITS=1, WIN_CYCLES=1, SETTLE_CYCLES=2 with cnt_a=1, cnt_b=0. Expect resp=0x01 after 6 cycles and osc_en high for exactly 1 cycle.
